traceback_unit: RTL

Survivor-memory traceback stage of the Viterbi decoder. It sits directly downstream of the survivor RAM (2048 × 8, 11-bit address, active-low enable, read data latched on negative clock edge). On each start request it walks the survivor bits backwards through time from a chosen end state, discards `TRACE_LEN` steps, then decodes 8 bits and presents them as one byte.

---
 rtl/traceback_unit.sv | 73 +++++++
 1 files changed

// File: rtl/traceback_unit.sv
// traceback_unit: Viterbi survivor traceback, one decoded byte per Start; TB_BEST_STATE_EN selects StartState (defined) or state 0x00 (undefined)
module traceback_unit #(
  parameter int TRACE_LEN = 32,
  parameter int WD_SLOT = 6
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic [7:0]         StartState,
  input  logic [WD_SLOT-1:0] WriteSlot,
  output logic [WD_SLOT+4:0] RamAddress,
  output logic               RamEnable_n,
  output logic               RamRWSelect,
  input  logic [7:0]         RamData,
  output logic               Busy,
  output logic [7:0]         DecodedByte,
  output logic               DecodedValid
);
  typedef enum logic [1:0] {IDLE, TRACE, DECODE, DONE} state_t;
  state_t state, state_nx;
  logic [7:0] cur_state, init_state, shreg;
  logic [WD_SLOT-1:0] slot;
  logic [5:0] cnt;
  logic d, last;
`ifdef TB_BEST_STATE_EN
  assign init_state = StartState;
`else
  logic unused_start;
  assign unused_start = ^StartState;
  assign init_state = 8'h00;
`endif
  assign d = RamData[cur_state[2:0]];
  assign RamAddress = {slot, cur_state[7:3]};
  assign RamEnable_n = !(state == TRACE || state == DECODE);
  assign RamRWSelect = 1'b1;
  assign Busy = state != IDLE;
  assign DecodedValid = state == DONE;
  // next state: TRACE_LEN discarded steps, 8 decode steps, one DONE cycle
  always_comb begin
    last = cnt == (state == TRACE ? 6'(TRACE_LEN - 1) : 6'd7);
    state_nx = state == IDLE ? (Start ? TRACE : IDLE) :
               state == DONE ? IDLE :
               !last ? state :
               state == TRACE ? DECODE : DONE;
  end
  // state register
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) state <= IDLE;
    else state <= state_nx;
  // traceback datapath: step to predecessor each RAM cycle, collect decoded bits
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      cur_state <= 8'h00;
      slot <= '0;
      cnt <= 6'd0;
      shreg <= 8'h00;
      DecodedByte <= 8'h00;
    end else if (state == IDLE) begin
      if (Start) begin
        cur_state <= init_state;
        slot <= WriteSlot;
        cnt <= 6'd0;
      end
    end else if (state != DONE) begin
      cur_state <= {d, cur_state[7:1]};
      slot <= slot - WD_SLOT'(1);
      cnt <= last ? 6'd0 : cnt + 6'd1;
      if (state == DECODE) begin
        shreg <= {shreg[6:0], cur_state[0]};
        if (last) DecodedByte <= {shreg[6:0], cur_state[0]};
      end
    end
endmodule
